// File: rtl/bp_fpga_host_uart_tx_mux.sv
// bp_fpga_host_uart_tx_mux
//   Multi-channel packet-to-UART transmitter for the FPGA host link. Fixed-priority
//   arbitration (channel 0 highest), locked for a whole packet. The granted packet is sent
//   byte 0 first, each byte as an 8N1/8N2 UART frame, LSB first, with no idle gap between
//   the bytes of one packet.
//
//   Optional feature: define BP_FPGA_HOST_UART_TX_PARITY_EN to insert an even-parity bit
//   after the data bits of every frame.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   pkt_i            num_ch_p packets, channel c at [c*pkt_width_p +: pkt_width_p]
//   pkt_v_i          per-channel valid
//   pkt_ready_and_o  per-channel ready (transfer on valid & ready)
//   tx_o             UART serial line, idle high
//   busy_o           high while a packet is being transmitted
//   pkt_done_o       one-cycle pulse when a packet's last stop bit completes
//   pkt_done_ch_o    channel of the completed packet, valid with pkt_done_o
module bp_fpga_host_uart_tx_mux #(
  parameter int unsigned num_ch_p      = 2,
  parameter int unsigned pkt_width_p   = 112,
  parameter int unsigned clk_per_bit_p = 10416,
  parameter int unsigned stop_bits_p   = 1
) (
  input  logic                                           clk_i,
  input  logic                                           reset_n_i,
  input  logic [num_ch_p*pkt_width_p-1:0]                pkt_i,
  input  logic [num_ch_p-1:0]                            pkt_v_i,
  output logic [num_ch_p-1:0]                            pkt_ready_and_o,
  output logic                                           tx_o,
  output logic                                           busy_o,
  output logic                                           pkt_done_o,
  output logic [((num_ch_p > 1) ? $clog2(num_ch_p) : 1)-1:0] pkt_done_ch_o
);

  localparam int unsigned ChW      = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int unsigned Bytes    = pkt_width_p / 8;
  localparam int unsigned BitCntW  = $clog2(clk_per_bit_p);
  localparam int unsigned ByteCntW = $clog2(Bytes) + 1;

  if (pkt_width_p % 8 != 0) begin : g_bad_width
    $error("pkt_width_p must be a multiple of 8");
  end
  if (clk_per_bit_p < 2) begin : g_bad_cpb
    $error("clk_per_bit_p must be >= 2");
  end
  if (stop_bits_p != 1 && stop_bits_p != 2) begin : g_bad_stop
    $error("stop_bits_p must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;   // data bit index, reused as stop-bit index
  logic [ByteCntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [pkt_width_p-1:0]  shift_q, shift_d;
  logic [ChW-1:0]          ch_q, ch_d;
  logic                    done_q, done_d;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic [ChW-1:0] grant;
  logic           bit_end;

  assign bit_end = (bit_cnt_q == BitCntW'(clk_per_bit_p - 1));

  // Lowest-index valid channel wins.
  always_comb begin
    grant = '0;
    for (int c = num_ch_p - 1; c >= 0; c--) begin
      if (pkt_v_i[c]) grant = ChW'(c);
    end
  end

  // Ready depends only on the valids of higher-priority channels, so a channel may see
  // ready before raising its own valid.
  always_comb begin
    logic seen;
    seen            = 1'b0;
    pkt_ready_and_o = '0;
    for (int c = 0; c < num_ch_p; c++) begin
      pkt_ready_and_o[c] = (state_q == StIdle) && reset_n_i && !seen;
      seen               = seen | pkt_v_i[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + BitCntW'(1);
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (|pkt_v_i) begin
          shift_d    = pkt_i[int'(grant) * pkt_width_p +: pkt_width_p];
          ch_d       = grant;
          byte_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = StData;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(stop_bits_p - 1)) begin
            bit_idx_d = '0;
            if (byte_cnt_q == ByteCntW'(Bytes - 1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + ByteCntW'(1);
              state_d    = StStart;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // tx_o decodes the state register directly so reset forces the line high at once.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      StStart:  tx_o = 1'b0;
      StData:   tx_o = shift_q[0];
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
      StParity: tx_o = par_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  assign pkt_done_o    = done_q;
  assign pkt_done_ch_o = ch_q;

endmodule

// File: tb/tb_bp_fpga_host_uart_tx_mux.sv
// Testbench for bp_fpga_host_uart_tx_mux (2 channels, 16-bit packets, 4 clocks per bit).
// A timing model predicts grants, per-byte frame start cycles and done pulses; a UART
// receiver decodes tx_o and compares against the predictions.
module tb_bp_fpga_host_uart_tx_mux;

  localparam int NumCh = 2;
  localparam int PW    = 16;
  localparam int Cpb   = 4;
  localparam int Stop  = 1;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
  localparam int Par   = 1;
`else
  localparam int Par   = 0;
`endif
  localparam int Nb    = 10 + Par + Stop - 1;  // bits per frame
  localparam int F     = Nb * Cpb;             // cycles per frame
  localparam int Bytes = PW / 8;

  logic                  clk;
  logic                  rst_n;
  logic [NumCh*PW-1:0]   pkt;
  logic [NumCh-1:0]      pkt_v;
  logic [NumCh-1:0]      pkt_ready;
  logic                  tx;
  logic                  busy;
  logic                  pkt_done;
  logic                  pkt_done_ch;

  bp_fpga_host_uart_tx_mux #(
    .num_ch_p      (NumCh),
    .pkt_width_p   (PW),
    .clk_per_bit_p (Cpb),
    .stop_bits_p   (Stop)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .pkt_i           (pkt),
    .pkt_v_i         (pkt_v),
    .pkt_ready_and_o (pkt_ready),
    .tx_o            (tx),
    .busy_o          (busy),
    .pkt_done_o      (pkt_done),
    .pkt_done_ch_o   (pkt_done_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] data; int start; } exp_byte_t;
  typedef struct { int ch; int cyc; } exp_done_t;

  exp_byte_t byte_q[$];
  exp_done_t done_q[$];

  // Monitor state
  int         model_free = 0;  // first cycle at which the model is idle again
  int         done_seen  = 0;
  bit         rx_active  = 1'b0;
  int         rx_start;
  int         rx_bit;
  logic [7:0] rx_data;
  logic       rx_par;
  exp_byte_t  eb;
  exp_done_t  ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      byte_q.delete();
      done_q.delete();
      rx_active  = 1'b0;
      model_free = 0;
    end else begin
      // Done pulse: must appear exactly at the predicted cycle, nowhere else.
      if (done_q.size() != 0 && cyc == done_q[0].cyc) begin
        ed = done_q.pop_front();
        check_eq("done_pulse", pkt_done, 1);
        check_eq("done_ch", pkt_done_ch, ed.ch);
      end else if (pkt_done) begin
        check_eq("done_unexpected", pkt_done, 0);
      end
      if (pkt_done) done_seen++;

      // UART receiver, sampling mid-bit.
      if (!rx_active && tx == 1'b0) begin
        rx_active = 1'b1;
        rx_start  = cyc;
        rx_bit    = 0;
      end
      if (rx_active && cyc == rx_start + rx_bit * Cpb + Cpb / 2) begin
        if (rx_bit == 0) check_eq("start_bit", tx, 0);
        else if (rx_bit <= 8) rx_data[rx_bit-1] = tx;
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
        else if (rx_bit == 9) rx_par = tx;
`endif
        else check_eq("stop_bit", tx, 1);
        if (rx_bit == Nb - 1) begin
          rx_active = 1'b0;
          check_eq("byte_expected", byte_q.size() != 0, 1);
          if (byte_q.size() != 0) begin
            eb = byte_q.pop_front();
            check_eq("byte_data", rx_data, eb.data);
            check_eq("byte_start_cycle", rx_start, eb.start);
`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
            check_eq("parity_bit", rx_par, ^eb.data);
`endif
          end
        end
        rx_bit++;
      end

      check_eq("busy", busy, cyc < model_free);

      // Arbitration model: ready and grant predicted from valids and model idleness.
      begin
        logic [NumCh-1:0] mready;
        logic             seen;
        int               g;
        int               hs;
        mready = '0;
        seen   = 1'b0;
        g      = -1;
        for (int c = 0; c < NumCh; c++) begin
          mready[c] = (cyc >= model_free) && !seen;
          if (pkt_v[c] && !seen) g = c;
          seen = seen | pkt_v[c];
        end
        if (|pkt_v) check_eq("ready", pkt_ready, mready);
        if (cyc >= model_free && g >= 0) begin
          hs = cyc + 1;  // handshake on the coming rising edge
          for (int i = 0; i < Bytes; i++) begin
            byte_q.push_back('{data: pkt[g*PW + i*8 +: 8], start: hs + i * F});
          end
          done_q.push_back('{ch: g, cyc: hs + Bytes * F});
          model_free = hs + Bytes * F;
        end
      end
    end
  end

  task automatic send(input int ch, input logic [PW-1:0] data);
    int n;
    @(posedge clk);
    #1;
    pkt[ch*PW +: PW] = data;
    pkt_v[ch]        = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pkt_ready[ch]) break;
      n++;
      if (n > 1000) begin
        check_eq("handshake_timeout", pkt_ready[ch], 1);
        pkt_v[ch] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    pkt_v[ch] = 1'b0;
  endtask

  task automatic wait_packet();
    repeat (Bytes * F + 10) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    pkt   = '0;
    pkt_v = 2'b01;

    // 1. Reset values (ready held low even with a valid present), then idle.
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", pkt_done, 0);
    check_eq("rst_done_ch", pkt_done_ch, 0);
    check_eq("rst_ready", pkt_ready, 2'b00);
    pkt_v = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_eq("idle_tx", tx, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", pkt_ready, 2'b11);

    // 2. Single packet on channel 1.
    send(1, 16'hA55A);
    wait_packet();

    // 3. Simultaneous valids: ch0 first, ch1 immediately after.
    fork
      send(0, 16'h1234);
      send(1, 16'hBEEF);
    join
    wait_packet();

    // 4. ch0 raises valid while ch1 is mid-packet.
    fork
      send(1, 16'hC3E1);
      begin
        repeat (30) @(posedge clk);
        send(0, 16'h5AA5);
      end
    join
    wait_packet();

    // 5. Reset during data bits of byte 0 (byte 0 is 0x00, so tx is low beforehand).
    send(0, 16'hAB00);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_eq("pre_reset_tx", tx, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midreset_tx", tx, 1);
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_ready", pkt_ready, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (Bytes * F) @(posedge clk);
    @(negedge clk);
    check_eq("post_reset_tx", tx, 1);
    check_eq("post_reset_busy", busy, 0);
    send(0, 16'h00FF);
    wait_packet();

`ifdef BP_FPGA_HOST_UART_TX_PARITY_EN
    // 6. Parity build: both bytes carry parity 1.
    send(0, 16'h0107);
    wait_packet();
`endif

    @(negedge clk);
    check_eq("sb_bytes_left", byte_q.size(), 0);
    check_eq("sb_done_left", done_q.size(), 0);
    check_eq("done_count", done_seen, 6 + Par);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_fpga_host_uart_tx_mux.md
Name: bp_fpga_host_uart_tx_mux

Overview:
- Multi-channel packet-to-UART transmitter for the FPGA host link.
- Arbitrates among num_ch_p packet sources (e.g. NBF responses, io_cmd-derived packets) with fixed priority, locked per packet.
- Serializes the granted packet byte-by-byte LSB-first and drives 8-bit UART frames on tx_o with built-in bit timing.
- Sits between the host IO blocks and the PC-host UART pin. Successor to the single-source tx path, generalised in channel count, packet width and stop bits.

Parameters:
- num_ch_p, 2: number of input channels; channel 0 has highest priority.
- pkt_width_p, 112: packet width in bits. Must be a multiple of 8. Bytes per packet = pkt_width_p/8.
- clk_per_bit_p, 10416: clocks per UART bit. Must be >= 2.
- stop_bits_p, 1: number of stop bits, 1 or 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- pkt_i  in  num_ch_p*pkt_width_p  packets. Channel c occupies bits [c*pkt_width_p +: pkt_width_p].
- pkt_v_i  in  num_ch_p  per-channel valid.
- pkt_ready_and_o  out  num_ch_p  per-channel ready; the transfer occurs when valid & ready.
- tx_o  out  1  UART serial line, idle high.
- busy_o  out  1  high while a packet is being transmitted.
- pkt_done_o  out  1  one-cycle pulse when a packet's last stop bit completes.
- pkt_done_ch_o  out  max(1,$clog2(num_ch_p))  channel index of the completed packet; valid only with pkt_done_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (reset_n_i). While reset is asserted:
  - tx_o=1, busy_o=0, pkt_done_o=0, pkt_done_ch_o=0, pkt_ready_and_o=0.
  - State=IDLE, and all counters and the shift register are cleared.
- Reset mid-frame: tx_o returns high immediately (asynchronously) and the in-flight packet is discarded, not resumed.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START for the next byte | IDLE).
- IDLE:
  - pkt_ready_and_o[c] = 1 iff no pkt_v_i[j] is high for any j<c. This is combinational on the valids only.
  - On handshake of channel g: capture pkt_i[g] into the shift register, latch g, set byte_cnt=0, go to START.
  - Simultaneous valids: the lowest index wins. The others hold until the block returns to IDLE.
- Outside IDLE: pkt_ready_and_o = 0. Packets are never interleaved.
- Bit timing: a bit counter counts 0..clk_per_bit_p-1. Each bit-time is exactly clk_per_bit_p cycles.
- START: tx_o=0 for one bit-time.
- DATA: 8 bit-times. tx_o = shift_reg[0]; shift right by 1 at the end of each bit-time.
- STOP: tx_o=1 for stop_bits_p bit-times. Then:
  - if byte_cnt < bytes-1: increment byte_cnt and go directly to START, with no idle gap;
  - else go to IDLE and pulse pkt_done_o.
- Byte order: byte 0 is pkt bits [7:0] and is sent first. Bit order within a byte is LSB first.
- Latency, for a handshake on the rising edge at cycle t:
  - tx_o goes low at cycle t+1 and busy_o=1 from t+1.
  - Frame length F = (10 + P + stop_bits_p - 1) * clk_per_bit_p cycles, where P=1 if parity is enabled, else 0.
  - Last stop bit ends after bytes*F cycles. pkt_done_o pulses at cycle t+bytes*F+1, busy_o drops and ready reasserts in the same cycle.
  - Back-to-back: a new handshake is possible in the pkt_done_o cycle.
- Counter widths: bit counter $clog2(clk_per_bit_p); byte counter $clog2(bytes)+1. No wrap occurs in legal operation.
- Elaboration assertions: pkt_width_p%8==0, clk_per_bit_p>=2, stop_bits_p in {1,2}.

Optional Feature:
- Macro BP_FPGA_HOST_UART_TX_PARITY_EN.
- When defined: a PARITY state follows DATA for one bit-time. It drives the even-parity bit, the XOR of the 8 data bits, and F grows by clk_per_bit_p.
- When undefined: DATA goes straight to STOP, and no parity logic is present.

Test Plan (num_ch_p=2, pkt_width_p=16, clk_per_bit_p=4, stop_bits_p=1, parity off unless stated):
1. Reset, then idle 50 cycles -> tx_o=1, busy_o=0, pkt_ready_and_o=2'b11, no pkt_done_o.
2. ch1 sends 0xA55A, handshake at t:
   - tx_o decodes as frame 0x5A then frame 0xA5, 40 cycles each, with no gap;
   - pkt_done_o=1 with pkt_done_ch_o=1 at t+81.
3. ch0=0x1234 and ch1=0xBEEF valid in the same cycle:
   - ch0 is granted first and ch1 is held; 0x34, 0x12 are sent, then 0xBEEF is sent immediately after pkt_done_o;
   - pkt_done_ch_o sequence is 0, then 1.
4. ch0 asserts valid while ch1's packet is mid-transmission -> pkt_ready_and_o stays 0 until ch1's pkt_done_o; ch1's bytes are uncorrupted.
5. Assert reset_n_i=0 during DATA of byte 0 -> tx_o=1 in the same cycle, busy_o=0. After release, the packet is not resumed and a new 0x00FF transmits cleanly.
6. With BP_FPGA_HOST_UART_TX_PARITY_EN, send 0x0107 -> byte 0x07 parity bit=1, byte 0x01 parity bit=1; frame=44 cycles; pkt_done_o at t+89.
